// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: finds the 10-bit word boundary by hunting for runs of
// control tokens, then decodes each aligned word as video, control and TERC4 in parallel.
module tmds_channel_decoder #(
  parameter int CTRL_RUN       = 12,
  parameter int SEARCH_TIMEOUT = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] tmds_raw,
  output logic       locked,
  output logic [3:0] offset,
  output logic [7:0] video_data,
  output logic [1:0] ctrl,
  output logic       ctrl_valid,
  output logic [3:0] terc4,
  output logic       terc4_valid
);
  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int TW = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam logic [RW-1:0] RUN_MAX  = RW'(CTRL_RUN);
  localparam logic [RW-1:0] RUN_LAST = RW'(CTRL_RUN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(SEARCH_TIMEOUT - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state_reg, state_next;
  logic [9:0]    prev_reg, a_q_reg;
  logic [3:0]    offset_reg, offset_next;
  logic [RW-1:0] run_cnt_reg, run_cnt_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic          skip_reg, skip_next;
  logic          locked_reg;
  logic [7:0]    video_reg;
  logic [1:0]    ctrl_reg;
  logic          ctrl_valid_reg;
  logic [3:0]    terc4_reg;
  logic          terc4_valid_reg;

  logic [19:0] window;
  logic [9:0]  a;
  logic [7:0]  q, video_next;
  logic [1:0]  ctrl_next;
  logic        ctrl_hit;
  logic [3:0]  terc4_next;
  logic        terc4_hit;
  logic        qual, timeout;

  // Earlier word sits in the low half, so window bit k is the k-th bit in time order.
  assign window = {tmds_raw, prev_reg};
  assign a      = window[offset_reg +: 10];

  always_comb begin
    ctrl_next = 2'b00;
    ctrl_hit  = 1'b1;
    case (a_q_reg)
      10'b1101010100: ctrl_next = 2'b00;
      10'b0010101011: ctrl_next = 2'b01;
      10'b0101010100: ctrl_next = 2'b10;
      10'b1010101011: ctrl_next = 2'b11;
      default:        ctrl_hit  = 1'b0;
    endcase
  end

  always_comb begin
    terc4_next = 4'd0;
    terc4_hit  = 1'b1;
    case (a_q_reg)
      10'b1010011100: terc4_next = 4'd0;
      10'b1001100011: terc4_next = 4'd1;
      10'b1011100100: terc4_next = 4'd2;
      10'b1011100010: terc4_next = 4'd3;
      10'b0101110001: terc4_next = 4'd4;
      10'b0100011110: terc4_next = 4'd5;
      10'b0110001110: terc4_next = 4'd6;
      10'b0100111100: terc4_next = 4'd7;
      10'b1011001100: terc4_next = 4'd8;
      10'b0100111001: terc4_next = 4'd9;
      10'b0110011100: terc4_next = 4'd10;
      10'b1011000110: terc4_next = 4'd11;
      10'b1010001110: terc4_next = 4'd12;
      10'b1001110001: terc4_next = 4'd13;
      10'b0101100011: terc4_next = 4'd14;
      10'b1011000011: terc4_next = 4'd15;
      default:        terc4_hit  = 1'b0;
    endcase
  end

  // Video: undo the optional inversion, then undo the XOR/XNOR chain.
  assign q             = a_q_reg[9] ? ~a_q_reg[7:0] : a_q_reg[7:0];
  assign video_next[0] = q[0];
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_video
      assign video_next[gi] = a_q_reg[8] ? (q[gi] ^ q[gi-1]) : ~(q[gi] ^ q[gi-1]);
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    offset_next  = offset_reg;
    run_cnt_next = run_cnt_reg;
    to_cnt_next  = to_cnt_reg + 1'b1;
    skip_next    = 1'b0;
    qual         = 1'b0;
    timeout      = (to_cnt_reg == TO_LAST);
    // skip_reg marks a_q still holding a word taken at the previous offset.
    if (skip_reg || !ctrl_hit) begin
      run_cnt_next = '0;
    end else if (run_cnt_reg != RUN_MAX) begin
      run_cnt_next = run_cnt_reg + 1'b1;
      qual         = (run_cnt_reg == RUN_LAST);
    end
    if (qual) begin
      state_next  = LOCKED;
      to_cnt_next = '0;
    end else if (timeout) begin
      state_next   = SEARCH;
      offset_next  = (offset_reg == 4'd9) ? 4'd0 : offset_reg + 4'd1;
      run_cnt_next = '0;
      to_cnt_next  = '0;
      skip_next    = 1'b1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_reg       <= SEARCH;
      prev_reg        <= '0;
      a_q_reg         <= '0;
      offset_reg      <= '0;
      run_cnt_reg     <= '0;
      to_cnt_reg      <= '0;
      skip_reg        <= 1'b0;
      locked_reg      <= 1'b0;
      video_reg       <= '0;
      ctrl_reg        <= '0;
      ctrl_valid_reg  <= 1'b0;
      terc4_reg       <= '0;
      terc4_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      prev_reg        <= tmds_raw;
      a_q_reg         <= a;
      offset_reg      <= offset_next;
      run_cnt_reg     <= run_cnt_next;
      to_cnt_reg      <= to_cnt_next;
      skip_reg        <= skip_next;
      locked_reg      <= (state_reg == LOCKED);
      video_reg       <= video_next;
      ctrl_reg        <= ctrl_next;
      ctrl_valid_reg  <= ctrl_hit;
      terc4_reg       <= terc4_next;
      terc4_valid_reg <= terc4_hit;
    end
  end

  assign locked      = locked_reg;
  assign offset      = offset_reg;
  assign video_data  = video_reg;
  assign ctrl        = ctrl_reg;
  assign ctrl_valid  = ctrl_valid_reg;
  assign terc4       = terc4_reg;
  assign terc4_valid = terc4_valid_reg;
endmodule
